// File: rtl/vedic_mac_8bit_seq.sv
// -----------------------------------------------------------------------------
// vedic_mac_8bit_seq
//
// Sequential 8x8 unsigned multiply-accumulate stage. A single 4x4 Vedic
// multiplier core (vedic_mult_4bit, defined below) is reused over four passes.
// Each pass picks one nibble of each latched operand, and the core's 8-bit
// partial product is shifted and added into a 16-bit product. On the last pass
// the finished product is added into a running accumulator.
//
// Optional feature:
//   VEDIC_MAC_SAT_EN - when defined, the accumulator saturates at all ones
//                      instead of wrapping modulo 2^ACC_W.
//
// Parameters:
//   ACC_W      accumulator width, 16..32 (default 24)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset (aborts any operation, zeroes acc)
//   in_valid   a, b, acc_clr are valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       8-bit unsigned operands
//   acc_clr    zero the accumulator before adding this product
//   out_valid  prod/acc hold the result of the last accepted operation
//   out_ready  downstream consumes the result
//   prod       16-bit product a*b
//   acc        ACC_W-bit running accumulator
// -----------------------------------------------------------------------------

// 4x4 unsigned multiplier using vertical-and-crosswise column sums: column k
// counts the one-bit products a[i]&b[j] with i+j == k, and the columns are then
// combined with their binary weights.
module vedic_mult_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] chain [0:7];

    assign chain[0] = 8'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_col
            logic [2:0] col;

            always_comb begin
                int k;
                col = 3'd0;
                k   = 0;
                for (int i = 0; i < 4; i++) begin
                    k = gi - i;
                    if (k >= 0 && k <= 3) begin
                        col = col + {2'b00, a[i[1:0]] & b[k[1:0]]};
                    end
                end
            end

            assign chain[gi + 1] = chain[gi] + ({5'd0, col} << gi);
        end
    endgenerate

    assign p = chain[7];
endmodule

module vedic_mac_8bit_seq #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      prod,
    output logic [ACC_W-1:0] acc
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       a_q, b_q;
    logic             clr_q;
    logic [1:0]       cnt;
    logic [15:0]      prod_reg;
    logic [ACC_W-1:0] acc_reg;

    logic [3:0]       core_a, core_b;
    logic [7:0]       core_p;
    logic [3:0]       shamt;
    logic [15:0]      pp_shift;
    logic [15:0]      prod_sum;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_upd;

    // cnt[1] selects the multiplicand nibble, cnt[0] the multiplier nibble,
    // giving lo*lo, lo*hi, hi*lo, hi*hi over passes 0..3.
    always_comb begin
        core_a = cnt[1] ? a_q[7:4] : a_q[3:0];
        core_b = cnt[0] ? b_q[7:4] : b_q[3:0];
    end

    vedic_mult_4bit u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    always_comb begin
        shamt = 4'd4;
        if (cnt == 2'd0) begin
            shamt = 4'd0;
        end else if (cnt == 2'd3) begin
            shamt = 4'd8;
        end
    end

    // The running 16-bit sum cannot overflow: the full product tops out at 0xFE01.
    assign pp_shift = {8'd0, core_p} << shamt;
    assign prod_sum = prod_reg + pp_shift;
    assign acc_base = clr_q ? '0 : acc_reg;

`ifdef VEDIC_MAC_SAT_EN
    logic [ACC_W:0] acc_sum;
    assign acc_sum = {1'b0, acc_base} + (ACC_W + 1)'(prod_sum);
    assign acc_upd = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
    assign acc_upd = acc_base + ACC_W'(prod_sum);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = MUL;
            MUL:  if (cnt == 2'd3) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            clr_q    <= 1'b0;
            cnt      <= 2'd0;
            prod_reg <= 16'd0;
            acc_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        clr_q    <= acc_clr;
                        cnt      <= 2'd0;
                        prod_reg <= 16'd0;
                    end
                end
                MUL: begin
                    prod_reg <= prod_sum;
                    cnt      <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        acc_reg <= acc_upd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign prod      = prod_reg;
    assign acc       = acc_reg;
endmodule
